// File: rtl/rom_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rom_arb_pkg
//   Shared types and constants for the ROM round-robin arbiter.
//   Contents:
//     ADDR_W_DEF / DATA_W_DEF  default ROM address / data widths
//     TAG_ID_W                 id field width of a response tag (covers 8 requesters)
//     id_width()               index width for a given number of requesters
//     tag_t                    {valid, id} record carried down the response pipe
// ----------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int TAG_ID_W   = 3;

    // Width of a requester index; at least one bit so the ports stay legal.
    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rom_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// rom_rr_arbiter_if
//   Request / response bundle between the client blocks and the arbiter.
//   Signals:
//     req_valid  per-requester read request
//     req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//     req_ready  one-hot grant
//     rsp_valid  one-hot response pulse
//     rsp_data   read data (broadcast)
//     rsp_id     index of the requester owning rsp_data
//   Modports: master = client side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface rom_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = rom_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W  = rom_arb_pkg::DATA_W_DEF
);
    import rom_arb_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/rom_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Scans the request vector
//   starting at the pointer and wrapping modulo NUM_REQ; the first set bit
//   wins.
//   Ports:
//     req    in   NUM_REQ  request vector
//     ptr    in   ID_W     index with highest priority this cycle
//     grant  out  NUM_REQ  one-hot grant (all zero when nothing requests)
//     idx    out  ID_W     index of the granted requester
//     any    out  1        a grant was issued
// ----------------------------------------------------------------------------
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = ID_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rom_rr_arbiter
//   Shares one synchronous-read ROM between NUM_REQ requesters. One request
//   is accepted per cycle in round-robin order; its address is registered
//   onto the ROM bus and a {valid,id} tag travels down a ROM_LAT+1 deep pipe
//   so the read data comes back tagged to the winner ROM_LAT+1 cycles later.
//   Ports:
//     clk       in   1        clock, all logic on posedge
//     rst       in   1        synchronous active-high reset
//     bus       slave         request/response bundle (rom_rr_arbiter_if)
//     rom_addr  out  ADDR_W   registered ROM address
//     rom_dout  in   DATA_W   ROM read data
// ----------------------------------------------------------------------------
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    rom_rr_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_dout
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] req_gated;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               accept;
    tag_t               new_tag;
    tag_t               pipe_q [0:ROM_LAT];
    tag_t               out_tag;
    logic [ID_W-1:0]    out_id;
    logic [DATA_W-1:0]  data_q;
    logic [NUM_REQ-1:0] rsp_valid_c;

    // Nothing can be granted while reset is asserted.
    assign req_gated = rst ? '0 : bus.req_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_gated),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (accept)
    );

    assign bus.req_ready = grant;

    always_comb begin
        new_tag = '0;
        if (accept) begin
            new_tag.valid = 1'b1;
            new_tag.id    = TAG_ID_W'(win_idx);
        end
    end

    // Pointer and ROM address register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q    <= '0;
            rom_addr <= '0;
        end else if (accept) begin
            ptr_q    <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
            rom_addr <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        end
    end

    // Tag pipe: stage s is valid s+1 cycles after the accept, so the last
    // stage lines up with the ROM output for that address.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this small register array is deliberately reset: stale
            // tags left in flight would otherwise fire responses after reset.
            for (int s = 0; s <= ROM_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q[0] <= new_tag;
            for (int s = 1; s <= ROM_LAT; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign out_tag = pipe_q[ROM_LAT];
    assign out_id  = out_tag.id[ID_W-1:0];

    // Last delivered data, so rsp_data holds steady across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (out_tag.valid) begin
            data_q <= rom_dout;
        end
    end

    always_comb begin
        rsp_valid_c = '0;
        if (out_tag.valid) begin
            rsp_valid_c[out_id] = 1'b1;
        end
    end

    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = out_tag.valid ? rom_dout : data_q;
    assign bus.rsp_id    = out_id;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rom_rr_arbiter
//   Directed bench for rom_rr_arbiter at default parameters with a one-cycle
//   synchronous ROM model holding mem[a] = 8'hA0 + a. A vector table drives
//   one row per cycle; a hand-written sequence covers reset mid-flight.
// ----------------------------------------------------------------------------
module tb_rom_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int NV      = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout = '0;

    int checks = 0;
    int errors = 0;

    rom_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    // ROM model: address sampled at the edge, data valid the next cycle.
    always @(posedge clk) begin
        rom_dout <= 8'hA0 + {4'h0, rom_addr};
    end

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [15:0] addr;
        logic [3:0]  ready;
        logic [3:0]  rv;
        logic [1:0]  id;
        logic [7:0]  data;
        logic [3:0]  raddr;
    } vec_t;

    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] a);
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = a;
        #1;
    endtask

    initial begin
        //            rst   valid  addr      ready  rv     id     data    raddr
        // reset with every requester asking
        vecs[0]  = '{1'b1, 4'hF, 16'h3210, 4'h0, 4'h0, 2'd0, 8'h00, 4'h0};
        vecs[1]  = '{1'b1, 4'hF, 16'h3210, 4'h0, 4'h0, 2'd0, 8'h00, 4'h0};
        vecs[2]  = '{1'b1, 4'hF, 16'h3210, 4'h0, 4'h0, 2'd0, 8'h00, 4'h0};
        // all four continuously valid, addr[i] = i; pointer wraps after 3
        vecs[3]  = '{1'b0, 4'hF, 16'h3210, 4'h1, 4'h0, 2'd0, 8'h00, 4'h0};
        vecs[4]  = '{1'b0, 4'hF, 16'h3210, 4'h2, 4'h0, 2'd0, 8'h00, 4'h0};
        vecs[5]  = '{1'b0, 4'hF, 16'h3210, 4'h4, 4'h1, 2'd0, 8'hA0, 4'h1};
        vecs[6]  = '{1'b0, 4'hF, 16'h3210, 4'h8, 4'h2, 2'd1, 8'hA1, 4'h2};
        vecs[7]  = '{1'b0, 4'hF, 16'h3210, 4'h1, 4'h4, 2'd2, 8'hA2, 4'h3};
        // requesters 0 and 3 only, pointer at 1: grants 3,0,3,0
        vecs[8]  = '{1'b0, 4'h9, 16'hD00C, 4'h8, 4'h8, 2'd3, 8'hA3, 4'h0};
        vecs[9]  = '{1'b0, 4'h9, 16'hD00C, 4'h1, 4'h1, 2'd0, 8'hA0, 4'hD};
        vecs[10] = '{1'b0, 4'h9, 16'hD00C, 4'h8, 4'h8, 2'd3, 8'hAD, 4'hC};
        vecs[11] = '{1'b0, 4'h9, 16'hD00C, 4'h1, 4'h1, 2'd0, 8'hAC, 4'hD};
        // idle: pipe drains, then rsp_data and rom_addr hold
        vecs[12] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h8, 2'd3, 8'hAD, 4'hC};
        vecs[13] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h1, 2'd0, 8'hAC, 4'hC};
        vecs[14] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd0, 8'hAC, 4'hC};
        // single request from 2 at address 5, response two cycles later
        vecs[15] = '{1'b0, 4'h4, 16'h0500, 4'h4, 4'h0, 2'd0, 8'hAC, 4'hC};
        vecs[16] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd0, 8'hAC, 4'h5};
        vecs[17] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h4, 2'd2, 8'hA5, 4'h5};
        // move pointer to 0, then req 1 valid for one cycle loses to req 0
        vecs[18] = '{1'b0, 4'h8, 16'hD000, 4'h8, 4'h0, 2'd0, 8'hA5, 4'h5};
        vecs[19] = '{1'b0, 4'h3, 16'h0010, 4'h1, 4'h0, 2'd0, 8'hA5, 4'hD};
        // single requester continuously valid: granted every cycle
        vecs[20] = '{1'b0, 4'h1, 16'h0000, 4'h1, 4'h8, 2'd3, 8'hAD, 4'h0};
        vecs[21] = '{1'b0, 4'h1, 16'h0000, 4'h1, 4'h1, 2'd0, 8'hA0, 4'h0};
        vecs[22] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h1, 2'd0, 8'hA0, 4'h0};
        vecs[23] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h1, 2'd0, 8'hA0, 4'h0};
        vecs[24] = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd0, 8'hA0, 4'h0};

        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_addr  = 16'h3210;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].addr);
            check($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
            check($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].rv));
            check($sformatf("row%0d rsp_data", i),  32'(bus.rsp_data),  32'(vecs[i].data));
            check($sformatf("row%0d rom_addr", i),  32'(rom_addr),      32'(vecs[i].raddr));
            if (vecs[i].rv != 4'h0 || vecs[i].rst) begin
                check($sformatf("row%0d rsp_id", i), 32'(bus.rsp_id), 32'(vecs[i].id));
            end
        end

        // Reset right after accepting req 1: its response must never appear.
        drive(1'b0, 4'h2, 16'h0090);
        check("rst_mid accept req1", 32'(bus.req_ready), 32'h2);
        drive(1'b1, 4'h3, 16'h0093);
        check("rst_mid ready during rst", 32'(bus.req_ready), 32'h0);
        drive(1'b0, 4'h3, 16'h0013);
        check("rst_mid no rsp T+2", 32'(bus.rsp_valid), 32'h0);
        check("rst_mid rsp_data cleared", 32'(bus.rsp_data), 32'h0);
        check("rst_mid rom_addr cleared", 32'(rom_addr), 32'h0);
        check("rst_mid first grant req0", 32'(bus.req_ready), 32'h1);
        drive(1'b0, 4'h0, 16'h0000);
        check("rst_mid no rsp T+3", 32'(bus.rsp_valid), 32'h0);
        check("rst_mid rom_addr req0", 32'(rom_addr), 32'h3);
        drive(1'b0, 4'h0, 16'h0000);
        check("rst_mid req0 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("rst_mid req0 rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rst_mid req0 rsp_data", 32'(bus.rsp_data), 32'hA3);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'h0, 16'h0000);
            check($sformatf("rst_mid idle%0d rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
            check($sformatf("rst_mid idle%0d rsp_data", c), 32'(bus.rsp_data), 32'hA3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
